// File: rtl/aes_buffered_round_unit.sv
// One AES-128 round (forward or inverse, normal or final) computed combinationally
// from in/key and captured in a single 128-bit output register.
module aes_buffered_round_unit #(
    parameter int ROUND_INDEX = 0,
    parameter int NUM_ROUNDS  = 10,
    parameter int INVERSE     = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out
);

    localparam bit IS_FINAL = (ROUND_INDEX == NUM_ROUNDS - 1);

    localparam logic [127:0] FWD_SBOX [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] INV_SBOX [16] = '{
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = (INVERSE != 0) ? INV_SBOX[x[7:4]] : FWD_SBOX[x[7:4]];
        return row[{~x[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant, enough for both {02,03,01} and {0E,0B,0D,09}.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? a2 : 8'h00) ^
               (m[2] ? a4 : 8'h00) ^ (m[3] ? a8 : 8'h00);
    endfunction

    logic [7:0]   w_in_b    [16];
    logic [7:0]   w_key_b   [16];
    logic [7:0]   w_pre_mix [16];
    logic [7:0]   w_mixed   [16];
    logic [7:0]   w_res     [16];
    logic [127:0] w_next;
    logic [127:0] r_out;

    for (genvar g = 0; g < 16; g++) begin : g_bytes
        assign w_in_b[g]              = in[127-8*g -: 8];
        assign w_key_b[g]             = key[127-8*g -: 8];
        assign w_next[127-8*g -: 8]   = w_res[g];
    end

    // The key is added before InvMixColumns but after MixColumns.
    if (INVERSE == 0) begin : g_fwd
        logic [7:0] w_sub [16];
        for (genvar g = 0; g < 16; g++) begin : g_sb
            assign w_sub[g] = sbox(w_in_b[g]);
            assign w_res[g] = w_mixed[g] ^ w_key_b[g];
        end
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign w_pre_mix[4*c+r] = w_sub[4*((c+r)%4)+r];
            end
        end
    end else begin : g_inv
        logic [7:0] w_shf [16];
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign w_shf[4*c+r] = w_in_b[4*((c+4-r)%4)+r];
            end
        end
        for (genvar g = 0; g < 16; g++) begin : g_sb
            assign w_pre_mix[g] = sbox(w_shf[g]) ^ w_key_b[g];
            assign w_res[g]     = w_mixed[g];
        end
    end

    if (IS_FINAL) begin : g_no_mix
        for (genvar g = 0; g < 16; g++) begin : g_pass
            assign w_mixed[g] = w_pre_mix[g];
        end
    end else begin : g_mix
        localparam logic [3:0] MC0 = (INVERSE != 0) ? 4'he : 4'h2;
        localparam logic [3:0] MC1 = (INVERSE != 0) ? 4'hb : 4'h3;
        localparam logic [3:0] MC2 = (INVERSE != 0) ? 4'hd : 4'h1;
        localparam logic [3:0] MC3 = (INVERSE != 0) ? 4'h9 : 4'h1;
        for (genvar c = 0; c < 4; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                assign w_mixed[4*c+r] = gmul(w_pre_mix[4*c+r],         MC0) ^
                                        gmul(w_pre_mix[4*c+(r+1)%4],   MC1) ^
                                        gmul(w_pre_mix[4*c+(r+2)%4],   MC2) ^
                                        gmul(w_pre_mix[4*c+(r+3)%4],   MC3);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out <= 128'h0;
        end else begin
            r_out <= w_next;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_aes_buffered_round_unit.sv
// Bench for aes_buffered_round_unit: four instances (fwd/inv x normal/final) driven
// in lock-step and compared against a matrix-level AES round model.
module tb_aes_buffered_round_unit;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] in_s;
    logic [127:0] key_s;
    logic [127:0] out_fn, out_ff, out_in, out_if;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    always #5 clock = ~clock;

    aes_buffered_round_unit #(.ROUND_INDEX(0), .NUM_ROUNDS(10), .INVERSE(0)) u_fn (
        .clock(clock), .reset(reset), .in(in_s), .key(key_s), .out(out_fn));
    aes_buffered_round_unit #(.ROUND_INDEX(9), .NUM_ROUNDS(10), .INVERSE(0)) u_ff (
        .clock(clock), .reset(reset), .in(in_s), .key(key_s), .out(out_ff));
    aes_buffered_round_unit #(.ROUND_INDEX(0), .NUM_ROUNDS(10), .INVERSE(1)) u_in (
        .clock(clock), .reset(reset), .in(in_s), .key(key_s), .out(out_in));
    aes_buffered_round_unit #(.ROUND_INDEX(9), .NUM_ROUNDS(10), .INVERSE(1)) u_if (
        .clock(clock), .reset(reset), .in(in_s), .key(key_s), .out(out_if));

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sboxes();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x] = s;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [127:0] s_in, input logic [127:0] k_in,
                                           input bit inv, input bit fin);
        logic [7:0]   st [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   kb [4][4];
        logic [7:0]   base [4];
        logic [127:0] res;
        for (int b = 0; b < 16; b++) begin
            st[b%4][b/4] = 8'(s_in >> (8*(15-b)));
            kb[b%4][b/4] = 8'(k_in >> (8*(15-b)));
        end
        if (inv) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        if (!inv) begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) st[r][c] = sb[st[r][c]];
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tmp[r][c] = st[r][(c+r)%4];
            st = tmp;
        end else begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) tmp[r][c] = st[r][(c+4-r)%4];
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) st[r][c] = isb[tmp[r][c]];
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) st[r][c] ^= kb[r][c];
        end
        if (!fin) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    tmp[r][c] = 8'h00;
                    for (int k = 0; k < 4; k++) tmp[r][c] ^= gf_mul(base[(k+4-r)%4], st[k][c]);
                end
            st = tmp;
        end
        if (!inv)
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) st[r][c] ^= kb[r][c];
        res = '0;
        for (int b = 0; b < 16; b++) res = (res << 8) | 128'(st[b%4][b/4]);
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick(input string tag);
        logic [127:0] e_fn, e_ff, e_in, e_if;
        if (reset == 1'b0) begin
            e_fn = '0; e_ff = '0; e_in = '0; e_if = '0;
        end else begin
            e_fn = model(in_s, key_s, 1'b0, 1'b0);
            e_ff = model(in_s, key_s, 1'b0, 1'b1);
            e_in = model(in_s, key_s, 1'b1, 1'b0);
            e_if = model(in_s, key_s, 1'b1, 1'b1);
        end
        @(posedge clock);
        #1;
        check({tag, "_fwd"},       out_fn, e_fn);
        check({tag, "_fwd_final"}, out_ff, e_ff);
        check({tag, "_inv"},       out_in, e_in);
        check({tag, "_inv_final"}, out_if, e_if);
    endtask

    initial begin
        build_sboxes();

        reset = 1'b0; in_s = rnd128(); key_s = rnd128();
        tick("reset0");
        in_s = rnd128(); key_s = rnd128();
        tick("reset1");

        reset = 1'b1; in_s = '0; key_s = '0;
        tick("zero");
        check("kat_zero_fwd", out_fn, {16{8'h63}});
        check("kat_zero_inv", out_in, {16{8'h52}});

        in_s  = 128'h00102030405060708090a0b0c0d0e0f0;
        key_s = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        tick("kat1");
        check("kat_fwd_round1", out_fn, 128'h89d810e8855ace682d1843d8cb128fe4);

        in_s  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
        key_s = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        tick("kat2");
        check("kat_fwd_final", out_ff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        in_s  = 128'h6353e08c0960e104cd70b751bacad0e7;
        key_s = 128'h000102030405060708090a0b0c0d0e0f;
        tick("kat3");
        check("kat_inv_final", out_if, 128'h00112233445566778899aabbccddeeff);

        in_s = {128{1'b1}}; key_s = rnd128();
        tick("ones");

        for (int i = 0; i < 12; i++) begin
            in_s = rnd128(); key_s = rnd128();
            tick("stream");
        end

        reset = 1'b0; in_s = rnd128(); key_s = rnd128();
        tick("mid_reset");
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_s = rnd128(); key_s = rnd128();
            tick("post_reset");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
